// File: rtl/mem_stage_pipelined_pkg.sv
// Shared definitions for the MEM pipeline stage: control-word layout, writeback
// source codes, access size codes, load funct3 codes and the FSM state encoding.
package mem_stage_pipelined_pkg;

  localparam int CW_W          = 14;
  localparam int CW_F3_LSB     = 0;
  localparam int CW_RD_LSB     = 3;
  localparam int CW_PC_SRC     = 8;
  localparam int CW_WB_SRC_LSB = 9;
  localparam int CW_MEM_WE     = 11;
  localparam int CW_RF_WB      = 12;
  localparam int CW_BRANCH     = 13;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;

  // Access size lives in funct3[1:0]; funct3[2] marks an unsigned load.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic       branch_taken;
    logic       rf_wb;
    logic       mem_we;
    logic [1:0] wb_src;
    logic       pc_src;
    logic [4:0] rd;
    logic [2:0] funct3;
  } ctrl_t;

  function automatic ctrl_t decode_cw(input logic [CW_W-1:0] cw);
    ctrl_t c;
    c.branch_taken = cw[CW_BRANCH];
    c.rf_wb        = cw[CW_RF_WB];
    c.mem_we       = cw[CW_MEM_WE];
    c.wb_src       = cw[CW_WB_SRC_LSB +: 2];
    c.pc_src       = cw[CW_PC_SRC];
    c.rd           = cw[CW_RD_LSB +: 5];
    c.funct3       = cw[CW_F3_LSB +: 3];
    return c;
  endfunction

endpackage

// File: rtl/mem_stage_pipelined_if.sv
// EX->MEM inputs, data-memory port and MEM/WB outputs of the MEM stage.
// misalign_trap exists only when MEM_MISALIGN_TRAP_EN is defined.
interface mem_stage_pipelined_if;
  import mem_stage_pipelined_pkg::*;

  logic            valid_ex;
  logic [CW_W-1:0] control_word_ex;
  logic [31:0]     ALU_result;
  logic [31:0]     calculated_adr;
  logic [31:0]     regfileb_ex;

  logic            stall_o;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;

  // dmem handshake: dmem_req holds with stable addr/data/be until a cycle with
  // dmem_ready=1; that cycle completes the access and dmem_rdata is valid in it.
  logic            dmem_req;
  logic            dmem_we;
  logic [31:0]     dmem_addr;
  logic [31:0]     dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_ready;
  logic [31:0]     dmem_rdata;

  logic            valid_wb;
  logic            rf_wb_wb;
  logic [4:0]      rd_wb;
  logic [31:0]     wb_data;
  mem_state_t      fsm_state;
`ifdef MEM_MISALIGN_TRAP_EN
  logic            misalign_trap;
`endif

  modport master (
    input  valid_ex, control_word_ex, ALU_result, calculated_adr, regfileb_ex,
    input  dmem_ready, dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output misalign_trap,
`endif
    output stall_o, redirect_valid, redirect_pc,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output valid_wb, rf_wb_wb, rd_wb, wb_data, fsm_state
  );

  modport slave (
    output valid_ex, control_word_ex, ALU_result, calculated_adr, regfileb_ex,
    output dmem_ready, dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    input  misalign_trap,
`endif
    input  stall_o, redirect_valid, redirect_pc,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  valid_wb, rf_wb_wb, rd_wb, wb_data, fsm_state
  );

endinterface

// File: rtl/mem_stage_pipelined_load_align.sv
// Load lane select and sign/zero extension of the returned memory word.
module load_align
  import mem_stage_pipelined_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfwords pick their lane from addr[1] only; addr[0] never moves the lane.
  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   data = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  data = {24'b0, byte_lane};
      F3_LHU:  data = {16'b0, half_lane};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_pipelined.sv
// MEM pipeline stage: EX/MEM register, data-memory access FSM, store lane
// steering, load alignment and MEM/WB register. Option: MEM_MISALIGN_TRAP_EN.
module mem_stage_pipelined
  import mem_stage_pipelined_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_pipelined_if.master bus
);

  logic            held_valid;
  logic [CW_W-1:0] held_cw;
  logic [31:0]     held_alu;
  logic [31:0]     held_adr;
  logic [31:0]     held_b;
  mem_state_t      state;
  ctrl_t           ctl;
  logic            is_load;
  logic            is_mem;
  logic            trap;
  logic            mem_active;
  logic            stall;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [31:0]     load_data;
  logic            valid_wb_q;
  logic            rf_wb_q;
  logic [4:0]      rd_q;
  logic [31:0]     wb_data_q;

  assign ctl     = decode_cw(held_cw);
  assign is_load = (ctl.wb_src == WB_MEM);
  assign is_mem  = is_load || ctl.mem_we;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((ctl.funct3[1:0] == SZ_HALF) && held_adr[0]) ||
                    (ctl.funct3[1] && (held_adr[1:0] != 2'b00));
  assign trap              = held_valid && is_mem && misalign;
  assign bus.misalign_trap = trap;
`else
  assign trap = 1'b0;
`endif

  assign mem_active = held_valid && is_mem && !trap;
  assign stall      = mem_active && !bus.dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid <= 1'b0;
      held_cw    <= '0;
      held_alu   <= '0;
      held_adr   <= '0;
      held_b     <= '0;
    end else if (!stall) begin
      held_valid <= bus.valid_ex;
      held_cw    <= bus.control_word_ex;
      held_alu   <= bus.ALU_result;
      held_adr   <= bus.calculated_adr;
      held_b     <= bus.regfileb_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (stall) state <= ST_WAIT;
        ST_WAIT: if (bus.dmem_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    be    = 4'b1111;
    wdata = held_b;
    case (ctl.funct3[1:0])
      SZ_BYTE: begin
        be    = 4'b0001 << held_adr[1:0];
        wdata = {4{held_b[7:0]}};
      end
      SZ_HALF: begin
        be    = 4'b0011 << {held_adr[1], 1'b0};
        wdata = {2{held_b[15:0]}};
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .rdata   (bus.dmem_rdata),
    .addr_lo (held_adr[1:0]),
    .funct3  (ctl.funct3),
    .data    (load_data)
  );

  // Stalled cycles push bubbles; the held instruction retires on its ready edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_wb_q <= 1'b0;
      rf_wb_q    <= 1'b0;
      rd_q       <= '0;
      wb_data_q  <= '0;
    end else if (stall) begin
      valid_wb_q <= 1'b0;
      rf_wb_q    <= 1'b0;
    end else begin
      valid_wb_q <= held_valid;
      rf_wb_q    <= held_valid && ctl.rf_wb && (ctl.rd != 5'd0) && !trap;
      rd_q       <= ctl.rd;
      wb_data_q  <= is_load ? load_data : held_alu;
    end
  end

  // Redirect only in the first held cycle so a stalled instruction cannot repeat it.
  assign bus.redirect_valid = held_valid && (ctl.branch_taken || ctl.pc_src) &&
                              (state == ST_IDLE);
  assign bus.redirect_pc    = held_adr;
  assign bus.stall_o        = stall;
  assign bus.dmem_req       = mem_active;
  assign bus.dmem_we        = mem_active && ctl.mem_we;
  assign bus.dmem_addr      = {held_adr[31:2], 2'b00};
  assign bus.dmem_wdata     = wdata;
  assign bus.dmem_be        = be;
  assign bus.valid_wb       = valid_wb_q;
  assign bus.rf_wb_wb       = rf_wb_q;
  assign bus.rd_wb          = rd_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.fsm_state      = state;

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Bench for mem_stage_pipelined: directed cases plus randomized ops against an
// arithmetic reference model; honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_stage_pipelined;
  import mem_stage_pipelined_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] exp_q[$];

  logic [2:0] ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] st_codes [3] = '{3'b000, 3'b001, 3'b010};
  logic [1:0] alu_srcs [3] = '{2'b00, 2'b10, 2'b11};

  mem_stage_pipelined_if bus ();

  mem_stage_pipelined dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [13:0] make_cw(input logic br, input logic rfwb, input logic we,
                                          input logic [1:0] wbs, input logic pcs,
                                          input logic [4:0] rd, input logic [2:0] f3);
    return {br, rfwb, we, wbs, pcs, rd, f3};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] v;
    int unsigned off;
    off = addr % 4;
    case (f3)
      3'b000, 3'b100: begin
        v = (word >> (8 * off)) % 32'd256;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        v = (word >> (16 * (off / 2))) % 32'd65536;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz;
    sz = f3 % 4;
    if (sz == 0) return 32'(1 << (addr % 4));
    if (sz == 1) return 32'(3 << (2 * ((addr % 4) / 2)));
    return 32'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] b);
    int unsigned sz;
    sz = f3 % 4;
    if (sz == 0) return (b % 32'd256) * 32'h01010101;
    if (sz == 1) return (b % 32'd65536) * 32'h00010001;
    return b;
  endfunction

  function automatic logic model_misalign(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
    int unsigned sz;
    sz = f3 % 4;
    if (sz == 1) return (addr % 2) != 0;
    if (sz >= 2) return (addr % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver: one instruction through the stage ----------------
  task automatic run_op(input logic br, input logic rfwb, input logic we, input logic [1:0] wbs,
                        input logic pcs, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] adr, input logic [31:0] b,
                        input logic [31:0] rdata, input int delay, input string tag);
    logic is_mem, trap, redir;
    int   d;
    is_mem = we || (wbs == 2'b01);
    trap   = is_mem && model_misalign(f3, adr);
    redir  = br || pcs;
    d      = (is_mem && !trap) ? delay : 0;
    exp_q.push_back((wbs == 2'b01) ? model_load(f3, adr, rdata) : alu);

    @(negedge clk);
    bus.valid_ex        = 1'b1;
    bus.control_word_ex = make_cw(br, rfwb, we, wbs, pcs, rd, f3);
    bus.ALU_result      = alu;
    bus.calculated_adr  = adr;
    bus.regfileb_ex     = b;
    bus.dmem_ready      = (d == 0);
    bus.dmem_rdata      = (d == 0) ? rdata : $urandom;
    @(posedge clk); #1;
    bus.valid_ex        = 1'b0;
    bus.control_word_ex = 14'($urandom);
    #1;
    check({tag, ".redirect"}, bus.redirect_valid, redir);
    if (redir) check({tag, ".redirect_pc"}, bus.redirect_pc, adr);
    check({tag, ".req"}, bus.dmem_req, is_mem && !trap);
`ifdef MEM_MISALIGN_TRAP_EN
    check({tag, ".trap"}, bus.misalign_trap, trap);
`endif
    if (is_mem && !trap) begin
      check({tag, ".addr"}, bus.dmem_addr, adr & 32'hFFFF_FFFC);
      check({tag, ".we"}, bus.dmem_we, we);
      if (we) begin
        check({tag, ".be"}, bus.dmem_be, model_be(f3, adr));
        check({tag, ".wdata"}, bus.dmem_wdata, model_wdata(f3, b));
      end
    end
    for (int i = 0; i < d; i++) begin
      check({tag, ".stall_hi"}, bus.stall_o, 1'b1);
      @(posedge clk); #1;
      check({tag, ".bubble"}, bus.valid_wb, 1'b0);
      check({tag, ".wait_state"}, bus.fsm_state, ST_WAIT);
      check({tag, ".no_re_redirect"}, bus.redirect_valid, 1'b0);
      check({tag, ".addr_stable"}, bus.dmem_addr, adr & 32'hFFFF_FFFC);
      check({tag, ".req_hold"}, bus.dmem_req, 1'b1);
      if (i == d - 1) begin
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = rdata;
      end
      #1;
    end
    check({tag, ".stall_lo"}, bus.stall_o, 1'b0);
    @(posedge clk); #1;
    bus.dmem_ready = 1'b0;
    check({tag, ".valid_wb"}, bus.valid_wb, 1'b1);
    check({tag, ".rf_wb_wb"}, bus.rf_wb_wb, rfwb && (rd != 5'd0) && !trap);
    check({tag, ".rd_wb"}, bus.rd_wb, rd);
    if (!trap) check({tag, ".wb_data"}, bus.wb_data, exp_q.pop_front());
    else void'(exp_q.pop_front());
    check({tag, ".redirect_one_cycle"}, bus.redirect_valid, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst                 = 1'b1;
    bus.valid_ex        = 1'b0;
    bus.control_word_ex = '0;
    bus.ALU_result      = '0;
    bus.calculated_adr  = '0;
    bus.regfileb_ex     = '0;
    bus.dmem_ready      = 1'b0;
    bus.dmem_rdata      = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid_wb", bus.valid_wb, 1'b0);
    check("rst.rf_wb_wb", bus.rf_wb_wb, 1'b0);
    check("rst.rd_wb", bus.rd_wb, 5'd0);
    check("rst.wb_data", bus.wb_data, 32'd0);
    check("rst.req", bus.dmem_req, 1'b0);
    check("rst.stall", bus.stall_o, 1'b0);
    check("rst.redirect", bus.redirect_valid, 1'b0);
    check("rst.state", bus.fsm_state, ST_IDLE);
    rst = 1'b0;

    // directed cases
    run_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd5, 3'b000, 32'h1234, 32'h0, 32'h0, 32'h0, 0, "add");
    run_op(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 3'b000, 32'h0, 32'h103, 32'hAB, 32'h0, 0, "sb");
    run_op(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd7, 3'b000, 32'h0, 32'h102, 32'h0, 32'h0080_0000, 3, "lb");
    run_op(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd7, 3'b100, 32'h0, 32'h102, 32'h0, 32'h0080_0000, 3, "lbu");
    run_op(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 3'b000, 32'h0, 32'h40, 32'h0, 32'h0, 0, "branch");
    run_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 3'b000, 32'hDEAD, 32'h0, 32'h0, 32'h0, 0, "rd0");
    run_op(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd4, 3'b001, 32'h0, 32'h101, 32'h0, 32'h8001_7FFF, 0, "lh101");
    run_op(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 3'b001, 32'h0, 32'h202, 32'h1234_BEEF, 32'h0, 1, "sh");

    // EX/MEM holds a younger op while a load waits, then captures it on the ready edge
    @(negedge clk);
    bus.valid_ex        = 1'b1;
    bus.control_word_ex = make_cw(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd3, 3'b010);
    bus.calculated_adr  = 32'h300;
    bus.dmem_ready      = 1'b0;
    @(posedge clk); #1;
    bus.control_word_ex = make_cw(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd9, 3'b000);
    bus.ALU_result      = 32'h55;
    #1;
    check("hold.stall", bus.stall_o, 1'b1);
    @(posedge clk); #1;
    check("hold.bubble", bus.valid_wb, 1'b0);
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.valid_ex   = 1'b0;
    bus.dmem_ready = 1'b0;
    check("hold.lw_data", bus.wb_data, 32'hCAFE_F00D);
    check("hold.lw_rd", bus.rd_wb, 5'd3);
    check("hold.next_no_req", bus.dmem_req, 1'b0);
    @(posedge clk); #1;
    check("hold.add_valid", bus.valid_wb, 1'b1);
    check("hold.add_rd", bus.rd_wb, 5'd9);
    check("hold.add_data", bus.wb_data, 32'h55);

    // reset while a load waits discards it
    @(negedge clk);
    bus.valid_ex        = 1'b1;
    bus.control_word_ex = make_cw(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd6, 3'b010);
    bus.calculated_adr  = 32'h200;
    bus.dmem_ready      = 1'b0;
    @(posedge clk); #1;
    bus.valid_ex = 1'b0;
    check("rstwait.req", bus.dmem_req, 1'b1);
    @(posedge clk); #1;
    check("rstwait.state", bus.fsm_state, ST_WAIT);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwait.req_drop", bus.dmem_req, 1'b0);
    check("rstwait.valid_wb", bus.valid_wb, 1'b0);
    check("rstwait.state_idle", bus.fsm_state, ST_IDLE);
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    check("rstwait.late_ready_valid", bus.valid_wb, 1'b0);
    check("rstwait.late_ready_wb", bus.rf_wb_wb, 1'b0);
    bus.dmem_ready = 1'b0;

    // randomized ops
    for (int n = 0; n < 40; n++) begin
      int kind;
      int dly;
      logic [31:0] adr;
      kind = $urandom_range(0, 3);
      dly  = $urandom_range(0, 3);
      adr  = $urandom;
      case (kind)
        0: run_op(1'b0, 1'($urandom), 1'b0, alu_srcs[$urandom_range(0, 2)], 1'b0, 5'($urandom),
                  3'($urandom), $urandom, adr, $urandom, $urandom, dly, "rnd_alu");
        1: run_op(1'b0, 1'($urandom), 1'b0, 2'b01, 1'b0, 5'($urandom),
                  ld_codes[$urandom_range(0, 4)], $urandom, adr, $urandom, $urandom, dly, "rnd_ld");
        2: run_op(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'($urandom),
                  st_codes[$urandom_range(0, 2)], $urandom, adr, $urandom, $urandom, dly, "rnd_st");
        default: run_op(1'($urandom), 1'($urandom), 1'b0, 2'b10, 1'b1, 5'($urandom),
                        3'($urandom), $urandom, adr, $urandom, $urandom, dly, "rnd_jmp");
      endcase
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
